uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver and the successor to the fixed 8N1 receiver. Frame format is set at elaboration: 5-9 data bits, optional even/odd parity, and 1 or 2 stop bits. Adds an input synchroniser, false-start rejection, parity and framing error flags, a break lockout, and a valid/ready output holding register with overrun detection. It sits between the rx pad and the UART top-level host interface.

Parameters:
NUM_CLKS_PER_BIT, 16, clocks per bit period (>=4); count width is $clog2(NUM_CLKS_PER_BIT).
DATA_BITS, 8, data bits per frame (5..9), LSB first.
PARITY_EN, 0, 1 adds a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk  input  1  clock; single clock domain.
rstn  input  1  reset; synchronous, active-low.
rx  input  1  serial input, asynchronous to clk.
dout  output  DATA_BITS  received data word; stable while valid=1.
valid  output  1  dout and the error flags hold an unread frame.
ready  input  1  consumer accepts the frame on a cycle where valid&&ready.
parity_err  output  1  parity mismatch for the frame in dout (qualified by valid).
frame_err  output  1  a stop bit was sampled as 0 for the frame in dout (qualified by valid).
overrun  output  1  one-cycle pulse: a completed frame was dropped because the holding register was full.
busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (rstn=0 at posedge clk): dout=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, state=IDLE, counters=0. Both synchroniser flops reset to 1.
- Synchroniser: 2-flop chain gives rx_s; all FSM decisions use rx_s, which lags rx by 2 cycles.
- States: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. Let H=(NUM_CLKS_PER_BIT-1)/2 and N=NUM_CLKS_PER_BIT.
- IDLE: if rx_s==0 -> START with count=0 (call this edge E0). Otherwise stay in IDLE.
- START: count increments each cycle. At count==H:
  - rx_s==0 -> DATA, count=0, bit_cnt=0.
  - rx_s==1 -> false start, return to IDLE; no output and no flags change.
- DATA: at count==N-1, sample rx_s into shift register bit[bit_cnt], set count=0, increment bit_cnt. Otherwise count increments. After bit DATA_BITS-1 -> PARITY if PARITY_EN, else STOP.
- PARITY: at count==N-1, compute perr = (XOR of data bits ^ rx_s ^ PARITY_ODD) != 0, then -> STOP.
- STOP: at count==N-1, sample rx_s; any 0 sample sets a sticky ferr. Repeat for STOP_BITS periods. On the final stop sample the frame completes:
  - Holding register free (valid==0), or freeing this cycle (valid&&ready): load dout, parity_err=perr, frame_err=ferr, valid=1.
  - Holding register full and not freeing (valid&&!ready): keep old contents, pulse overrun=1 for one cycle, drop the new frame.
  - Next state: ferr with all data bits 0 -> BREAK_WAIT; otherwise IDLE.
- BREAK_WAIT: stay until rx_s==1, then -> IDLE. A held-low line therefore produces exactly one frame.
- Latency: valid rises at edge E0 + (H+1) + N*(DATA_BITS+PARITY_EN+STOP_BITS). For N=16, 8N1 this is E0+152.
- Handshake: valid clears on the edge after valid&&ready unless a new frame loads on that same edge, in which case valid stays 1. While valid=1, dout and the flags do not change except by that load.
- Errored frames are still delivered, with their flag set. Flags are meaningful only while valid=1.
- Reset asserted mid-frame aborts the frame immediately; the partial frame is lost and no overrun or error is reported.
- busy=1 in every state except IDLE.

Test Plan:
- Default 8N1, N=16: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop 1), ready=1 -> valid for exactly 1 cycle at E0+152, dout=0xA5, parity_err=0, frame_err=0.
- PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 1 -> dout=0x03, parity_err=1. Repeat with parity bit 0 -> parity_err=0.
- Glitch: rx low for 4 clocks then high -> START rejects at count==7, state returns to IDLE, valid never rises, busy returns to 0.
- Overrun: ready=0, send 0x11 then 0x22 back-to-back -> dout stays 0x11, overrun pulses once at the end of frame 2. Then ready=1 -> valid drops the next cycle.
- Break: hold rx low for 30 bit times -> exactly one frame with dout=0x00 and frame_err=1. No further frames until rx returns high; then 0x5A is received correctly.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2: send 0x41 with a good parity bit, first stop=1, second stop=0 -> frame_err=1, parity_err=0, dout=0x41. Then assert rstn=0 mid-frame on the next byte -> all outputs return to 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// UART receiver with elaboration-time frame format (5-9 data bits, optional parity, 1-2 stops).
// Synchronised rx, false-start rejection, error flags, break lockout, valid/ready holding register.
//
// state        | meaning
// S_IDLE       | line idle, waiting for rx_s low
// S_START      | half-bit check of start bit (false-start rejection)
// S_DATA       | sampling data bits, LSB first
// S_PARITY     | sampling parity bit
// S_STOP       | sampling stop bit(s); last sample completes the frame
// S_BREAK_WAIT | line held low after an all-zero framing error; wait for rx_s high
module uart_rx_cfg #(
  parameter int NUM_CLKS_PER_BIT = 16,
  parameter int DATA_BITS        = 8,
  parameter int PARITY_EN        = 0,
  parameter int PARITY_ODD       = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(NUM_CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_HALF = CW'((NUM_CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          C_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sync;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_busy;

  logic w_rx_s;
  logic w_last_stop;
  logic w_ferr_next;

  assign w_rx_s      = r_sync[1];
  assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;
  assign w_ferr_next = r_ferr | ~w_rx_s;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_sync       <= 2'b11;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_dout       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], rx};
      r_overrun <= 1'b0;
      // A frame load later in this block overrides the handshake clear.
      if (r_valid && ready) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state    <= S_DATA;
              r_bit_cnt  <= '0;
              r_stop_cnt <= 1'b0;
              r_perr     <= 1'b0;
              r_ferr     <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == C_LAST) begin
            r_shift[r_bit_cnt] <= w_rx_s;
            r_cnt              <= '0;
            r_bit_cnt          <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == B_LAST) r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (r_cnt == C_LAST) begin
            r_perr  <= (^r_shift) ^ w_rx_s ^ C_ODD;
            r_cnt   <= '0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (!w_last_stop) begin
              r_stop_cnt <= 1'b1;
              r_ferr     <= w_ferr_next;
            end else begin
              if (!r_valid || ready) begin
                r_dout       <= r_shift;
                r_parity_err <= r_perr;
                r_frame_err  <= w_ferr_next;
                r_valid      <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              // All-zero data with a bad stop is a break: hold off until the line recovers.
              if (w_ferr_next && (r_shift == '0)) begin
                r_state <= S_BREAK_WAIT;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_BREAK_WAIT: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule
